regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the 4x32 register file (2 combinational read ports, 1 synchronous write port)
//  between two requesters, A and B. Reads run in parallel: A uses read port 1, B uses read port 2.
//  Writes contend for the single write port. Round-robin arbitration, with an optional
//  bounded lock for back-to-back write bursts.
//  Sits between the datapath/loader masters and the register file.
// PARAMETERS
//  DATA_W    32  register width
//  ADDR_W    2   register index width (2**ADDR_W registers)
//  MAX_LOCK  4   max consecutive locked write grants to one requester (>=1)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  {a,b}_valid   in   1       request valid; must hold until ready
//  {a,b}_ready   out  1       request accepted this cycle (valid&ready)
//  {a,b}_wr      in   1       1=write, 0=read
//  {a,b}_lock    in   1       ask to keep the write port after this write
//  {a,b}_addr    in   ADDR_W  register index
//  {a,b}_wdata   in   DATA_W  write data
//  {a,b}_rvalid  out  1       read response valid, 1-cycle pulse
//  {a,b}_rdata   out  DATA_W  read response data (registered)
//  rf_rs1        out  ADDR_W  regfile read port 1 index (from A)
//  rf_rs2        out  ADDR_W  regfile read port 2 index (from B)
//  rf_read1      in   DATA_W  regfile read data 1
//  rf_read2      in   DATA_W  regfile read data 2
//  rf_wr         out  1       regfile write enable
//  rf_waddr      out  ADDR_W  regfile write index
//  rf_wdata      out  DATA_W  regfile write data
// BEHAVIOUR
//  - While rst=1: all outputs 0. state=IDLE, rr_ptr=A, lock_cnt=0, pending responses discarded.
//    Reset mid-lock or mid-response obeys the same rule. The rvalid due on the next cycle is suppressed.
//  - Reads: ready=1 combinationally whenever valid&!wr. rf_rs1/2 follow a/b_addr.
//    rdata is registered at accept and returned with rvalid on cycle N+1 (latency 1).
//    Back-to-back reads are accepted every cycle.
//  - Writes: at most one grant per cycle. The grantee gets ready=1, and rf_wr/rf_waddr/rf_wdata carry
//    its request the same cycle. The regfile commits on that clock edge.
//    When rf_wr=0, rf_waddr/rf_wdata=0.
//  - The loser keeps ready=0 and holds its request. Each requester is in order: a stalled write
//    blocks that requester's later reads.
//  - FSM {IDLE, LOCK_A, LOCK_B}:
//    IDLE: a lone writer wins. If both write, rr_ptr wins and rr_ptr flips to the other side.
//      If the winner has lock=1: go to LOCK_<winner>, lock_cnt=1.
//    LOCK_x: only x may be granted writes; the other side's writes stall. Each grant to x
//      increments lock_cnt. Exit to IDLE, with rr_ptr = other side, when any of these hold:
//      x has no valid write this cycle; x is granted with lock=0; the grant makes lock_cnt==MAX_LOCK.
//    Reads from either side are never stalled by LOCK.
//  - Same-cycle read and write to the same address (either side): the read returns the OLD value.
//  - Starvation bound: a waiting writer is granted within MAX_LOCK+1 cycles.
//  - Width rule: addresses are used unmodified. No wrap or arithmetic on data.
// CONFIGURATION
//  RFARB_BYPASS_EN defined: a read accepted in the same cycle as a granted write to the same
//    address returns the new wdata (write-to-read forwarding).
//  Not defined: returns the old rf_read value (as in BEHAVIOUR).
// STRUCTURE
//  Shared package rfarb_pkg holds:
//    - state enum ARB_IDLE/ARB_LOCK_A/ARB_LOCK_B
//    - requester id constants REQ_A=0/REQ_B=1
//    - default widths
//  One sub-module, rfarb_rr_grant: combinational 2-way grant from {req_a, req_b, rr_ptr, state}.
//    Top level holds the FSM, lock_cnt, and the response registers.
// TESTING
//  1 Reset: rst=1 for 3 cycles with a_valid=b_valid=1 -> all outputs 0. After release rr_ptr=A.
//  2 Parallel reads: A reads r1, B reads r2 (preloaded 0x11111111 / 0x22222222) -> both ready
//    same cycle; next cycle a_rdata=0x11111111, b_rdata=0x22222222, both rvalid=1.
//  3 Write conflict: A wr r0=0xAAAA0000 and B wr r3=0xBBBB0000 in the same cycle -> A granted first,
//    B the next cycle; then a new A+B conflict grants B first.
//  4 Lock burst: MAX_LOCK=4; A issues 6 locked writes while B holds a write -> A granted 4 times,
//    B granted in cycle 5, A's 5th write granted in cycle 6.
//  5 Same-address hazard: B writes r2=0xDEADBEEF while A reads r2 (old 0x12345678) -> a_rdata is
//    0x12345678; with RFARB_BYPASS_EN it is 0xDEADBEEF.
//  6 Reset mid-lock: assert rst in LOCK_A after 2 grants -> next cycle all outputs 0, state IDLE,
//    no rvalid pulse.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared types and defaults for the two-requester register-file port arbiter.
package rfarb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_MAX_LOCK = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_A = 2'd1,
    ARB_LOCK_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rfarb_rr_grant.sv
// Combinational 2-way write grant: the lock owner only while locked, else a lone
// requester, else the round-robin pointer's side on contention.
module rfarb_rr_grant
  import rfarb_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       rr_ptr_i,
  input  arb_state_e state_i,
  output logic       gnt_a_o,
  output logic       gnt_b_o
);

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    case (state_i)
      ARB_LOCK_A: gnt_a_o = req_a_i;
      ARB_LOCK_B: gnt_b_o = req_b_i;
      default: begin
        if (req_a_i && req_b_i) begin
          gnt_a_o = (rr_ptr_i == REQ_A);
          gnt_b_o = (rr_ptr_i == REQ_B);
        end else begin
          gnt_a_o = req_a_i;
          gnt_b_o = req_b_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a 2R/1W register file between A and B: reads in parallel (1-cycle registered response),
// writes round-robin with bounded lock; losers stall on ready=0. RFARB_BYPASS_EN forwards same-cycle writes to reads.
module regfile_port_arbiter
  import rfarb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wr,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wr,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  arb_state_e        state_q;
  logic              rr_ptr_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  logic [CNT_W-1:0]  lock_cnt_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  logic              wreq_a, wreq_b, rd_a, rd_b;
  logic              gnt_a, gnt_b;
  logic              win_lock, own_gnt, own_lock;
  logic [DATA_W-1:0] rd_dat_a, rd_dat_b;

  // Everything is qualified by !rst so the block is silent while held in reset.
  assign wreq_a = a_valid & a_wr & ~rst;
  assign wreq_b = b_valid & b_wr & ~rst;
  assign rd_a   = a_valid & ~a_wr & ~rst;
  assign rd_b   = b_valid & ~b_wr & ~rst;

  rfarb_rr_grant u_grant (
    .req_a_i  (wreq_a),
    .req_b_i  (wreq_b),
    .rr_ptr_i (rr_ptr_q),
    .state_i  (state_q),
    .gnt_a_o  (gnt_a),
    .gnt_b_o  (gnt_b)
  );

  assign a_ready  = rd_a | gnt_a;
  assign b_ready  = rd_b | gnt_b;
  assign rf_rs1   = rst ? '0 : a_addr;
  assign rf_rs2   = rst ? '0 : b_addr;
  assign rf_wr    = gnt_a | gnt_b;
  assign rf_waddr = gnt_a ? a_addr  : (gnt_b ? b_addr  : '0);
  assign rf_wdata = gnt_a ? a_wdata : (gnt_b ? b_wdata : '0);

`ifdef RFARB_BYPASS_EN
  assign rd_dat_a = (rf_wr && (rf_waddr == a_addr)) ? rf_wdata : rf_read1;
  assign rd_dat_b = (rf_wr && (rf_waddr == b_addr)) ? rf_wdata : rf_read2;
`else
  assign rd_dat_a = rf_read1;
  assign rd_dat_b = rf_read2;
`endif

  assign win_lock   = gnt_a ? a_lock : b_lock;
  assign own_gnt    = (state_q == ARB_LOCK_A) ? gnt_a  : gnt_b;
  assign own_lock   = (state_q == ARB_LOCK_A) ? a_lock : b_lock;
  assign lock_cnt_d = lock_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= REQ_A;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt_a || gnt_b) begin
            if (wreq_a && wreq_b) rr_ptr_q <= gnt_a ? REQ_B : REQ_A;
            if (win_lock) begin
              // A one-grant lock budget is exhausted by the entry grant itself.
              if (MAX_LOCK > 1) begin
                state_q    <= gnt_a ? ARB_LOCK_A : ARB_LOCK_B;
                lock_cnt_q <= CNT_W'(1);
              end else begin
                rr_ptr_q <= gnt_a ? REQ_B : REQ_A;
              end
            end
          end
        end
        ARB_LOCK_A, ARB_LOCK_B: begin
          if (own_gnt && own_lock && (lock_cnt_d != MAX_CNT)) begin
            lock_cnt_q <= lock_cnt_d;
          end else begin
            state_q    <= ARB_IDLE;
            lock_cnt_q <= '0;
            rr_ptr_q   <= (state_q == ARB_LOCK_A) ? REQ_B : REQ_A;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= rd_a;
      b_rvalid_q <= rd_b;
      if (rd_a) a_rdata_q <= rd_dat_a;
      if (rd_b) b_rdata_q <= rd_dat_b;
    end
  end

  assign a_rvalid = a_rvalid_q & ~rst;
  assign b_rvalid = b_rvalid_q & ~rst;
  assign a_rdata  = rst ? '0 : a_rdata_q;
  assign b_rdata  = rst ? '0 : b_rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file and read-response scoreboard.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_wr, a_lock, a_rvalid;
  logic [1:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_wr, b_lock, b_rvalid;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [1:0]  rf_rs1, rf_rs2, rf_waddr;
  logic [31:0] rf_read1, rf_read2, rf_wdata;
  logic        rf_wr;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.DATA_W(32), .ADDR_W(2), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_lock(a_lock),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_lock(b_lock),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_read1(rf_read1), .rf_read2(rf_read2),
    .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Register file model: combinational reads, write on the clock edge, bulk preload.
  logic [31:0] rf [4];
  logic [31:0] pl_img [4];
  logic        pl_en;
  assign rf_read1 = rf[rf_rs1];
  assign rf_read2 = rf[rf_rs2];
  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= pl_img[i];
    end else if (rf_wr) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  int          k;
  logic        exp_ga [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    a_valid = 0; a_wr = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_wr = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {21'b0, a_ready, b_ready, a_rvalid, b_rvalid, rf_wr, rf_rs1, rf_rs2, rf_waddr}, 32'd0);
    chk({tag, "_a_rdata"}, a_rdata, 32'd0);
    chk({tag, "_b_rdata"}, b_rdata, 32'd0);
    chk({tag, "_wdata"}, rf_wdata, 32'd0);
  endtask

  // Response monitor: every rvalid pulse must match the oldest predicted read.
  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      if (exp_a.size() == 0) chk("a_rvalid_unexpected", {31'b0, a_rvalid}, 32'd0);
      else chk("a_rdata", a_rdata, exp_a.pop_front());
    end
    if (b_rvalid === 1'b1) begin
      if (exp_b.size() == 0) chk("b_rvalid_unexpected", {31'b0, b_rvalid}, 32'd0);
      else chk("b_rdata", b_rdata, exp_b.pop_front());
    end
  end

  initial begin
    clr();
    rst = 1;
    pl_en = 1;
    pl_img = '{32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    // Reset with both sides requesting.
    a_valid = 1; a_addr = 2;
    b_valid = 1; b_wr = 1; b_addr = 3; b_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("reset");
    end

    // Parallel reads, then a back-to-back read on A.
    step(); rst = 0; pl_en = 0; clr();
    a_valid = 1; a_addr = 1; b_valid = 1; b_addr = 2;
    @(negedge clk);
    chk("rd_a_ready", {31'b0, a_ready}, 32'd1);
    chk("rd_b_ready", {31'b0, b_ready}, 32'd1);
    chk("rd_rs1", {30'b0, rf_rs1}, 32'd1);
    chk("rd_rs2", {30'b0, rf_rs2}, 32'd2);
    exp_a.push_back(32'h1111_1111);
    exp_b.push_back(32'h2222_2222);
    step(); b_valid = 0; a_addr = 3;
    @(negedge clk);
    chk("rd_b2b_ready", {31'b0, a_ready}, 32'd1);
    exp_a.push_back(32'h3333_3333);

    // Write conflicts: A first after reset, B on the next conflict.
    step(); clr();
    a_valid = 1; a_wr = 1; a_addr = 0; a_wdata = 32'hAAAA_0000;
    b_valid = 1; b_wr = 1; b_addr = 3; b_wdata = 32'hBBBB_0000;
    @(negedge clk);
    chk("wc1_a_ready", {31'b0, a_ready}, 32'd1);
    chk("wc1_b_ready", {31'b0, b_ready}, 32'd0);
    chk("wc1_waddr", {30'b0, rf_waddr}, 32'd0);
    chk("wc1_wdata", rf_wdata, 32'hAAAA_0000);
    step(); a_valid = 0;
    @(negedge clk);
    chk("wc1_b_late_ready", {31'b0, b_ready}, 32'd1);
    chk("wc1_b_waddr", {30'b0, rf_waddr}, 32'd3);
    chk("wc1_b_wdata", rf_wdata, 32'hBBBB_0000);
    step(); clr();
    a_valid = 1; a_wr = 1; a_addr = 1; a_wdata = 32'h0101_0101;
    b_valid = 1; b_wr = 1; b_addr = 2; b_wdata = 32'h0202_0202;
    @(negedge clk);
    chk("wc2_b_ready", {31'b0, b_ready}, 32'd1);
    chk("wc2_a_ready", {31'b0, a_ready}, 32'd0);
    chk("wc2_waddr", {30'b0, rf_waddr}, 32'd2);
    step(); b_valid = 0;
    @(negedge clk);
    chk("wc2_a_late_ready", {31'b0, a_ready}, 32'd1);
    chk("wc2_a_waddr", {30'b0, rf_waddr}, 32'd1);
    step(); clr();
    a_valid = 1; a_addr = 0; b_valid = 1; b_addr = 3;
    @(negedge clk);
    chk("idle_rf_wr", {31'b0, rf_wr}, 32'd0);
    chk("idle_waddr", {30'b0, rf_waddr}, 32'd0);
    chk("idle_wdata", rf_wdata, 32'd0);
    exp_a.push_back(32'hAAAA_0000);
    exp_b.push_back(32'hBBBB_0000);

    // Lock burst: A holds six locked writes against one waiting B write.
    step(); clr();
    k = 0;
    a_valid = 1; a_wr = 1; a_lock = 1; a_addr = 0; a_wdata = 32'h4000_0000;
    b_valid = 1; b_wr = 1; b_addr = 3; b_wdata = 32'hB4B4_B4B4;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        step();
        if (exp_ga[c-1]) begin
          k++;
          a_addr = 2'(k);
          a_wdata = 32'h4000_0000 + 32'(k);
          if (k == 6) a_valid = 0;
        end else begin
          b_valid = 0;
        end
      end
      @(negedge clk);
      chk("lock_a_ready", {31'b0, a_ready}, {31'b0, exp_ga[c]});
      chk("lock_b_ready", {31'b0, b_ready}, {31'b0, (c == 4)});
      chk("lock_wdata", rf_wdata, exp_ga[c] ? (32'h4000_0000 + 32'(k)) : 32'hB4B4_B4B4);
    end

    // Same-address hazard: A reads r2 while B writes it.
    step(); clr();
    a_valid = 1; a_wr = 1; a_addr = 2; a_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("hz_pre_a_ready", {31'b0, a_ready}, 32'd1);
    step(); clr();
    a_valid = 1; a_addr = 2;
    b_valid = 1; b_wr = 1; b_addr = 2; b_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("hz_a_ready", {31'b0, a_ready}, 32'd1);
    chk("hz_b_ready", {31'b0, b_ready}, 32'd1);
`ifdef RFARB_BYPASS_EN
    exp_a.push_back(32'hDEAD_BEEF);
`else
    exp_a.push_back(32'h1234_5678);
`endif
    step(); clr();
    a_valid = 1; a_addr = 2; b_valid = 1; b_addr = 3;
    @(negedge clk);
    chk("hz_post_a_ready", {31'b0, a_ready}, 32'd1);
    exp_a.push_back(32'hDEAD_BEEF);
    exp_b.push_back(32'hB4B4_B4B4);

    // Reset in the middle of a lock, with a B read response in flight.
    step(); clr();
    a_valid = 1; a_wr = 1; a_lock = 1; a_addr = 0; a_wdata = 32'h6000_0000;
    @(negedge clk);
    chk("rml_g1", {31'b0, a_ready}, 32'd1);
    step();
    a_addr = 1; a_wdata = 32'h6000_0001;
    b_valid = 1; b_addr = 1;
    @(negedge clk);
    chk("rml_g2", {31'b0, a_ready}, 32'd1);
    chk("rml_b_read_in_lock", {31'b0, b_ready}, 32'd1);
    step();
    rst = 1; a_addr = 2; a_wdata = 32'h6000_0002; b_valid = 0;
    @(negedge clk);
    chk_quiet("rml_reset");
    step(); rst = 0; clr();
    b_valid = 1; b_wr = 1; b_addr = 3; b_wdata = 32'h7777_7777;
    @(negedge clk);
    chk("rml_idle_b_ready", {31'b0, b_ready}, 32'd1);
    chk("rml_idle_waddr", {30'b0, rf_waddr}, 32'd3);
    chk("rml_no_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'd0);
    step(); clr();
    a_valid = 1; a_addr = 3; b_valid = 1; b_addr = 0;
    @(negedge clk);
    exp_a.push_back(32'h7777_7777);
    exp_b.push_back(32'h6000_0000);
    step(); clr();
    @(negedge clk);
    #1;
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
